// File: rtl/fc1_input_serializer.sv
// Ping-pong frame buffer in front of FC1: takes one signed feature per cycle and
// replays each complete frame as an unbroken burst of three-feature beats.
module fc1_input_serializer #(
  parameter int unsigned INPUT_NUM = 48,
  parameter int unsigned LANES     = 3,
  parameter int unsigned DATA_W    = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_data,
  output logic                     o_ready,
  output logic                     o_valid,
  output logic signed [DATA_W-1:0] data_out_1,
  output logic signed [DATA_W-1:0] data_out_2,
  output logic signed [DATA_W-1:0] data_out_3,
  output logic                     o_last,
  output logic [7:0]               o_frame_cnt
);

  localparam int unsigned BEATS  = INPUT_NUM / LANES;
  localparam int unsigned IDX_W  = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(INPUT_NUM - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  // Frame storage, deliberately left without reset.
  logic signed [DATA_W-1:0] mem [2][INPUT_NUM];

  logic [1:0]               full_q, full_d;
  logic                     wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0]         wr_idx_q, wr_idx_d;
  logic                     rd_bank_q, rd_bank_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic [0:0]               state_q, state_d;
  logic                     valid_q, valid_d;
  logic                     last_q, last_d;
  logic signed [DATA_W-1:0] d1_q, d1_d;
  logic signed [DATA_W-1:0] d2_q, d2_d;
  logic signed [DATA_W-1:0] d3_q, d3_d;
  logic [7:0]               cnt_q, cnt_d;

  logic             wr_en;
  logic             wr_done;
  logic             rd_last;
  logic             rd_other;
  logic [IDX_W-1:0] rd_base;

  assign o_ready     = ~full_q[wr_bank_q];
  assign o_valid     = valid_q;
  assign o_last      = last_q;
  assign data_out_1  = d1_q;
  assign data_out_2  = d2_q;
  assign data_out_3  = d3_q;
  assign o_frame_cnt = cnt_q;

  assign wr_en    = i_valid && o_ready;
  assign wr_done  = wr_en && (wr_idx_q == LAST_IDX);
  assign rd_last  = (state_q == ST_STREAM) && (beat_q == LAST_BEAT);
  assign rd_other = ~rd_bank_q;
  assign rd_base  = IDX_W'(beat_q) * IDX_W'(LANES);

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_bank_q][wr_idx_q] <= i_data;
    end
  end

  // Write side: fill the current bank, then hand it over via its full flag.
  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    if (wr_en) begin
      if (wr_done) begin
        wr_idx_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end
  end

  // The read clear and the write set always target different banks, so both apply.
  always_comb begin
    full_d = full_q;
    if (rd_last) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (wr_done) begin
      full_d[wr_bank_q] = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    rd_bank_d = rd_bank_q;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    d1_d      = d1_q;
    d2_d      = d2_q;
    d3_d      = d3_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = ST_STREAM;
          beat_d  = '0;
        end
      end
      ST_STREAM: begin
        valid_d = 1'b1;
        last_d  = rd_last;
        d1_d    = mem[rd_bank_q][rd_base];
        d2_d    = mem[rd_bank_q][rd_base + IDX_W'(1)];
        d3_d    = mem[rd_bank_q][rd_base + IDX_W'(2)];
        if (rd_last) begin
          rd_bank_d = rd_other;
          cnt_d     = cnt_q + 8'd1;
          beat_d    = '0;
          // Chain straight into the other bank only if it was already complete.
          if (!full_q[rd_other]) begin
            state_d = ST_IDLE;
          end
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_bank_q <= 1'b0;
      beat_q    <= '0;
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      d1_q      <= '0;
      d2_q      <= '0;
      d3_q      <= '0;
      cnt_q     <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_bank_q <= rd_bank_d;
      beat_q    <= beat_d;
      state_q   <= state_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      d1_q      <= d1_d;
      d2_q      <= d2_d;
      d3_q      <= d3_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fc1_input_serializer.sv
// Directed bench for fc1_input_serializer: reset, single, continuous, gapped,
// forced back-to-back and mid-stream reset scenarios.
module tb_fc1_input_serializer;

  localparam int BEATS = 16;

  logic               i_clk;
  logic               i_rst;
  logic               i_valid;
  logic signed [15:0] i_data;
  logic               o_ready;
  logic               o_valid;
  logic signed [15:0] data_out_1;
  logic signed [15:0] data_out_2;
  logic signed [15:0] data_out_3;
  logic               o_last;
  logic [7:0]         o_frame_cnt;

  fc1_input_serializer #(
    .INPUT_NUM (48),
    .LANES     (3),
    .DATA_W    (16)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_ready     (o_ready),
    .o_valid     (o_valid),
    .data_out_1  (data_out_1),
    .data_out_2  (data_out_2),
    .data_out_3  (data_out_3),
    .o_last      (o_last),
    .o_frame_cnt (o_frame_cnt)
  );

  typedef struct {
    int d1;
    int d2;
    int d3;
    int last;
    int cyc;
  } beat_t;

  beat_t beats_q[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    stalls = 0;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_valid) begin
      beat_t bt;
      bt.d1   = int'(data_out_1);
      bt.d2   = int'(data_out_2);
      bt.d3   = int'(data_out_3);
      bt.last = int'(o_last);
      bt.cyc  = cyc;
      beats_q.push_back(bt);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " o_valid"}, int'(o_valid), 0);
    check({tag, " o_last"}, int'(o_last), 0);
    check({tag, " d1"}, int'(data_out_1), 0);
    check({tag, " d2"}, int'(data_out_2), 0);
    check({tag, " d3"}, int'(data_out_3), 0);
    check({tag, " frame_cnt"}, int'(o_frame_cnt), 0);
    check({tag, " o_ready"}, int'(o_ready), 1);
  endtask

  // Asserts reset mid-cycle, checks the immediate effect, then releases it.
  task automatic do_reset(input string tag);
    @(negedge i_clk);
    #2;
    i_valid = 1'b0;
    i_rst   = 1'b0;
    #1;
    check_idle_outputs(tag);
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    beats_q.delete();
  endtask

  task automatic send(input int val, output int acc_cyc);
    logic ready_seen;
    i_valid = 1'b1;
    i_data  = 16'(val);
    for (int t = 0; t < 200; t++) begin
      ready_seen = o_ready;
      @(posedge i_clk);
      #1;
      if (ready_seen) begin
        acc_cyc = cyc;
        i_valid = 1'b0;
        return;
      end
      stalls++;
    end
    check("send timeout", 0, 1);
    acc_cyc = -1;
    i_valid = 1'b0;
  endtask

  // Pops one frame of beats; same_val means every feature equals base.
  task automatic check_frame(input string tag, input int base, input int start_cyc,
                             input bit same_val);
    beat_t bt;
    int    e;
    if (beats_q.size() < BEATS) begin
      check({tag, " beats"}, beats_q.size(), BEATS);
      return;
    end
    for (int b = 0; b < BEATS; b++) begin
      bt = beats_q.pop_front();
      e  = same_val ? base : base + 3 * b;
      check($sformatf("%s b%0d d1", tag, b), bt.d1, e);
      check($sformatf("%s b%0d d2", tag, b), bt.d2, same_val ? base : e + 1);
      check($sformatf("%s b%0d d3", tag, b), bt.d3, same_val ? base : e + 2);
      check($sformatf("%s b%0d last", tag, b), bt.last, (b == BEATS - 1) ? 1 : 0);
      check($sformatf("%s b%0d cycle", tag, b), bt.cyc, start_cyc + b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int last_acc;
    int ends[4];
    int rel;
    int waited;

    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    #2;
    i_rst = 1'b0;
    #1;
    check_idle_outputs("rst");
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;

    // Single frame, value = index.
    for (int k = 0; k < 48; k++) begin
      send(k, acc);
    end
    last_acc = acc;
    wait_cycles(22);
    check_frame("single", 0, last_acc + 2, 1'b0);
    check("single extra", beats_q.size(), 0);
    check("single frame_cnt", int'(o_frame_cnt), 1);

    // Continuous: four frames at full input rate.
    do_reset("rst2");
    stalls = 0;
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 48; k++) begin
        send(k - 24, acc);
      end
      ends[f] = acc;
    end
    wait_cycles(22);
    for (int f = 0; f < 4; f++) begin
      check_frame($sformatf("cont f%0d", f), -24, ends[f] + 2, 1'b0);
    end
    check("cont extra", beats_q.size(), 0);
    check("cont stalls", stalls, 0);
    check("cont frame_cnt", int'(o_frame_cnt), 4);

    // Gapped input: one idle cycle between features.
    do_reset("rst3");
    for (int k = 0; k < 48; k++) begin
      send(k, acc);
      if (k < 47) wait_cycles(1);
    end
    last_acc = acc;
    check("gap early beats", beats_q.size(), 0);
    wait_cycles(22);
    check_frame("gap", 0, last_acc + 2, 1'b0);
    check("gap extra", beats_q.size(), 0);
    check("gap frame_cnt", int'(o_frame_cnt), 1);

    // Forced back-to-back: hold the reader idle until both banks are full.
    do_reset("rst4");
    force dut.state_q = 1'b0;
    for (int k = 0; k < 48; k++) send(k, acc);
    for (int k = 0; k < 48; k++) send(1000 + k, acc);
    check("b2b both full ready", int'(o_ready), 0);
    i_valid = 1'b1;
    i_data  = 16'sd9999;
    wait_cycles(3);
    check("b2b stalled ready", int'(o_ready), 0);
    i_valid = 1'b0;
    check("b2b no early beats", beats_q.size(), 0);
    release dut.state_q;
    rel = cyc;
    wait_cycles(16);
    check("b2b ready before free", int'(o_ready), 0);
    wait_cycles(1);
    check("b2b ready after free", int'(o_ready), 1);
    wait_cycles(20);
    check_frame("b2b f0", 0, rel + 2, 1'b0);
    check_frame("b2b f1", 1000, rel + 18, 1'b0);
    check("b2b extra", beats_q.size(), 0);
    check("b2b frame_cnt", int'(o_frame_cnt), 2);

    // Reset mid-stream, then a fresh all-100 frame.
    do_reset("rst5");
    for (int k = 0; k < 48; k++) send(k, acc);
    waited = 0;
    while (beats_q.size() < 8 && waited < 60) begin
      wait_cycles(1);
      waited++;
    end
    check("mid reached beat 7", (beats_q.size() >= 8) ? 1 : 0, 1);
    do_reset("mid rst");
    wait_cycles(5);
    check("mid stale beats", beats_q.size(), 0);
    for (int k = 0; k < 48; k++) send(100, acc);
    last_acc = acc;
    wait_cycles(22);
    check_frame("mid new", 100, last_acc + 2, 1'b1);
    check("mid extra", beats_q.size(), 0);
    check("mid frame_cnt", int'(o_frame_cnt), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc1_input_serializer.md
# fc1_input_serializer

- Feeds the first fully connected layer with input frames of `INPUT_NUM` signed 16-bit features.
- Accepts one feature per cycle from the flatten/pool stage and stores each frame in a two-bank ping-pong buffer.
- Replays each complete frame as `INPUT_NUM/LANES` contiguous beats of three features per beat.
- Sits directly in front of the FC1 layer, driving its `i_valid` and `data_in_1..3`. FC1 counts its own beats and has no backpressure, so every frame is emitted as an unbroken burst.

## Interface
Parameters:
- `INPUT_NUM`, 48, features per frame; must be a multiple of `LANES`.
- `LANES`, 3, features per output beat; fixed at 3.
- `DATA_W`, 16, feature width.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  asynchronous active-low reset.
- `i_valid`  in  1  input feature valid.
- `i_data`  in  `DATA_W` signed  input feature.
- `o_ready`  out  1  a feature is accepted when `i_valid && o_ready`.
- `o_valid`  out  1  output beat valid; drives FC1 `i_valid`.
- `data_out_1`, `data_out_2`, `data_out_3`  out  `DATA_W` signed each  features 3b, 3b+1 and 3b+2 of beat b.
- `o_last`  out  1  high on the final beat (b = `INPUT_NUM/LANES`-1) of a frame.
- `o_frame_cnt`  out  8  number of frames fully emitted, modulo 256.

## Operation
Buffer and write side:
- Two banks of `INPUT_NUM` x `DATA_W`. Bank storage is not reset.
- A `full[1:0]` flag per bank.
- Write side state: `wr_bank` and `wr_idx`, both 0 at reset.
- Each accepted feature is written to `bank[wr_bank][wr_idx]`.
- At `wr_idx == INPUT_NUM-1`: set `full[wr_bank]`, toggle `wr_bank`, `wr_idx <= 0`.
- `o_ready = !full[wr_bank]`, combinational from registered state.
- Input order is preserved: feature k of a frame appears at beat k/3, lane k%3.

Read side FSM (`rd_bank` and beat counter `b` are 0 at reset):
- IDLE: if `full[rd_bank]`, go to STREAM with `b <= 0`. Outputs `o_valid` and `o_last` are registered 0.
- STREAM, every cycle:
  - `o_valid <= 1`.
  - `data_out_(k+1) <= bank[rd_bank][3b+k]` for k = 0..2.
  - `o_last <= (b == BEATS-1)`, where BEATS = `INPUT_NUM/LANES`.
  - `b <= b+1`.
- On the last beat:
  - clear `full[rd_bank]`, toggle `rd_bank`, increment `o_frame_cnt`;
  - if `full` of the other bank is already set, stay in STREAM with `b <= 0`; otherwise go to IDLE.
- A burst is never interrupted and `o_valid` never drops mid-frame.
- `data_out_*` hold their last value while `o_valid` is 0.

Boundary conditions:
- A write completing a bank and a read freeing the other bank on the same edge: both updates apply.
- Read freeing bank X while `wr_bank == X` is stalled: `o_ready` rises in the next cycle.
- Both banks full: `o_ready` = 0 and input is stalled. This cannot occur at 1 feature/cycle with the default parameters but must be handled.
- `i_valid` while `o_ready` = 0: the feature is ignored and the write state is unchanged.
- Reset mid-frame: every flag, pointer, counter and output is cleared immediately; partial frames are discarded.

## Timing
Reset values:
- `o_valid` = 0, `o_last` = 0.
- `data_out_1..3` = 0.
- `o_frame_cnt` = 0.
- `o_ready` = 1, because `full` = 0.

Latency and throughput:
- The 48th feature is accepted at edge E.
- IDLE moves to STREAM at E+1.
- Beat 0 is visible after E+2; beat 15, with `o_last`, is visible after E+17.
- Sustained rate: 1 feature/cycle in and 3 features/cycle out.
- The writer never stalls at full input rate; one bank drains in 16 cycles while the other fills in 48.
- Back-to-back full banks produce a burst of 2xBEATS consecutive `o_valid` cycles with no gap.

## Test plan
- **Reset:** assert `i_rst` = 0 asynchronously mid-cycle -> all outputs 0 immediately and `o_ready` = 1.
- **Single frame:** send features 0..47 (value = index) -> `o_valid` high 16 consecutive cycles starting 2 cycles after the last accept.
  - Beat b shows (3b, 3b+1, 3b+2); beat 15 = (45, 46, 47) with `o_last` = 1.
  - `o_frame_cnt` = 1 afterwards.
- **Continuous:** 4 frames at 1 feature/cycle with values -24..23 -> `o_ready` never 0.
  - Each frame is emitted as 16 beats with correct signed values, e.g. beat 0 = (-24, -23, -22).
  - `o_frame_cnt` = 4.
- **Gapped input:** `i_valid` toggled every other cycle for one frame -> output identical to the single-frame case; no `o_valid` before the 48th accept.
- **Forced back-to-back:** preload both banks using a bench override of the read-side start; or use the parameter `INPUT_NUM` = 3, which exercises BEATS = 1 (`o_last` on every beat).
  - Two consecutive frames must show no `o_valid` gap, `o_last` on each final beat, and `rd_bank` alternating.
- **Reset mid-stream:** reset asserted at beat 7 of a burst, then a fresh frame of all 100 -> no stale beats after reset; the new frame emits 16 beats of (100, 100, 100) and `o_frame_cnt` = 1.
